vault_reader: RTL and testbench
===============================

# vault_reader

Read-side companion to the password store memory: accepts a request for one stored 256-bit entry, or for all stored entries, reads it through the memory's asynchronous read port and streams it out as bytes over a valid/ready interface. It sits between the 16-entry store and the byte-oriented host link (UART/transport) and never writes the memory. An out-of-range request is rejected with an error pulse and produces no bytes.

## Interface
- DATA_W, 256: entry width in bits.
- ADDR_W, 4: memory address width (16 entries).
- BYTE_W, 8: output byte width; DATA_W/BYTE_W = 32 bytes per entry.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_all  in  1  1 = stream entries 0..count-1; 0 = single entry.
- req_addr  in  ADDR_W  entry index (ignored when req_all=1).
- entry_count  in  ADDR_W+1  number of valid entries (0..16).
- mem_addr  out  ADDR_W  read address to memory.
- mem_q  in  DATA_W  memory read data, combinational on mem_addr.
- out_valid  out  1  byte available.
- out_ready  in  1  sink accepts byte.
- out_data  out  BYTE_W  current byte.
- out_last  out  1  marks final byte of the transfer.
- err  out  1  one-cycle pulse: request rejected.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, SEND.
- IDLE: req_ready=1. On req_valid: latch req_all, req_addr (or 0 for all-mode) and entry_count.
  - Reject if entry_count==0, or single-mode with req_addr >= entry_count: err=1 next cycle, stay IDLE.
  - Else -> LOAD.
- LOAD (one cycle): mem_addr = current index; capture mem_q into 256-bit shift register at end of cycle; byte counter := 0; -> SEND.
- SEND: out_valid=1, out_data = bits [255:248] of shift register (MSB byte first). On out_valid&&out_ready: shift left 8, counter+1.
  - After byte 31 transfers: single-mode, or all-mode with index == latched count-1 -> IDLE; otherwise index+1, -> LOAD.
- out_last=1 only on byte 31 of the final entry of the transfer.
- Entry snapshot taken at LOAD; memory writes during SEND do not affect bytes in flight. In all-mode later entries read current contents; latched count is not updated.
- Reset values: state IDLE, req_ready=1 once rst_n high, mem_addr=0, out_valid=0, out_data=0, out_last=0, err=0, busy=0, shift register 0.
- rst_n asserted mid-transfer: abandon immediately, all outputs to reset values, no further bytes.

## Timing
- Request accepted at edge N (req_valid&&req_ready): LOAD in cycle N+1, first out_valid in cycle N+2.
- Rejected request at edge N: err high cycle N+1 only; req_ready stays 1.
- Back-pressure: out_data, out_valid, out_last held stable while out_ready=0.
- Full-rate sink: single entry = 32 consecutive bytes, cycles N+2..N+33; back in IDLE cycle N+34.
- All-mode: exactly one bubble cycle (LOAD, out_valid=0) between entries; k entries take 33k+1 cycles with out_ready=1.
- Counter and index arithmetic unsigned; counter 5 bits, no wrap past 31; index ADDR_W bits, entry_count==16 reaches index 15 without overflow.

## Structure
- Shared package vault_pkg: DATA_W, ADDR_W, BYTE_W, BYTES_PER_ENTRY (32), state enum {IDLE, LOAD, SEND}; the memory and this block import the same widths.
- One sub-module: byte_serializer (load strobe, 256-bit shift register, 5-bit byte counter, valid/ready, done flag). vault_reader holds the FSM, request latches and error logic.

## Test plan
- Store entry 3 = 0x00..1F byte pattern (byte 0 = 0x00 MSB), count=5, single req addr=3, out_ready=1 -> bytes 0x00..0x1F cycles N+2..N+33, out_last only on 0x1F.
- Single req addr=5 with count=5, and all-mode with count=0 -> err one-cycle pulse, no out_valid, busy stays 0.
- All-mode, count=3, entries 0xAA.., 0xBB.., 0xCC.. fill -> 96 bytes, one bubble between entries, out_last only on 96th byte, mem_addr 0,1,2.
- Random out_ready (50%) on single req -> byte sequence identical, out_data stable whenever out_valid&&!out_ready.
- Overwrite entry 3 during its SEND -> streamed bytes match pre-write contents.
- Drop rst_n at byte 10 -> out_valid=0, busy=0 asynchronously; after release, new req addr=0 streams entry 0 correctly.

Source files
------------

// File: rtl/vault_pkg.sv
// Shared widths, state encoding and request check for the password store
// and its read-side streaming block.
package vault_pkg;

    localparam int DATA_W          = 256;
    localparam int ADDR_W          = 4;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_ENTRY = DATA_W / BYTE_W;
    localparam int CNT_W           = $clog2(BYTES_PER_ENTRY);
    localparam int NUM_ENTRIES     = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // A request is refused when the store is empty, or when a single-entry
    // request points at or beyond the number of valid entries.
    function automatic logic request_rejected(
        input logic              all_mode,
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W:0]   count
    );
        logic bad;
        if (count == {(ADDR_W+1){1'b0}}) begin
            bad = 1'b1;
        end else if (!all_mode && ({1'b0, addr} >= count)) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/vault_reader_byte_serializer.sv
// Holds one 256-bit entry snapshot and hands it out MSB byte first over a
// valid/ready handshake, counting the bytes that have been accepted.
module byte_serializer
    import vault_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              active,
    input  logic [DATA_W-1:0] din,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              last_byte,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_ENTRY - 1);

    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              fire_s;

    assign fire_s    = active && out_ready;
    assign out_valid = active;
    assign out_data  = shift_r[DATA_W-1 -: BYTE_W];
    assign last_byte = active && (cnt_r == LAST_BYTE);
    assign done      = fire_s && (cnt_r == LAST_BYTE);

    // Snapshot on load, then shift one byte out per accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load) begin
            shift_r <= din;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (fire_s) begin
            shift_r <= {shift_r[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            if (cnt_r != LAST_BYTE) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/vault_reader.sv
// Read-side streamer for the 16-entry password store: validates a request,
// reads one or all entries through the asynchronous port and streams bytes.
module vault_reader
    import vault_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_all,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W:0]   entry_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              err,
    output logic              busy
);

    // Counts above the store size are clamped so all-mode can never run
    // the index past the last entry.
    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(NUM_ENTRIES);

    state_t            state_r;
    state_t            next_state_s;
    logic              all_r;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W:0]   cnt_r;
    logic              err_r;
    logic              accept_s;
    logic              reject_s;
    logic              load_s;
    logic              advance_s;
    logic              final_s;
    logic              active_s;
    logic              last_byte_s;
    logic              done_s;

    assign req_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign active_s  = (state_r == SEND);
    assign mem_addr  = idx_r;
    assign err       = err_r;
    assign out_last  = last_byte_s && final_s;

    // The entry being sent is the last one of the transfer.
    always_comb begin
        final_s = 1'b0;
        if (!all_r) begin
            final_s = 1'b1;
        end else if ({1'b0, idx_r} == (cnt_r - (ADDR_W+1)'(1))) begin
            final_s = 1'b1;
        end else begin
            final_s = 1'b0;
        end
    end

    // Next-state and control strobes for the request/load/send sequence.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (request_rejected(req_all, req_addr, entry_count)) begin
                        reject_s = 1'b1;
                    end else begin
                        accept_s     = 1'b1;
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                load_s       = 1'b1;
                next_state_s = SEND;
            end
            SEND: begin
                if (done_s) begin
                    if (final_s) begin
                        next_state_s = IDLE;
                    end else begin
                        advance_s    = 1'b1;
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = SEND;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latches: mode, current index and entry count for the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_r <= 1'b0;
            idx_r <= {ADDR_W{1'b0}};
            cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (accept_s) begin
            all_r <= req_all;
            idx_r <= req_all ? {ADDR_W{1'b0}} : req_addr;
            cnt_r <= (entry_count > MAX_COUNT) ? MAX_COUNT : entry_count;
        end else if (advance_s) begin
            idx_r <= idx_r + ADDR_W'(1);
        end else begin
            all_r <= all_r;
            idx_r <= idx_r;
            cnt_r <= cnt_r;
        end
    end

    // One-cycle error pulse for a refused request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= reject_s;
        end
    end

    byte_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .active    (active_s),
        .din       (mem_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .last_byte (last_byte_s),
        .done      (done_s)
    );

endmodule

// File: tb/tb_vault_reader.sv
// Self-checking bench for vault_reader: request table plus hand-written
// back-pressure, overwrite and mid-transfer reset sequences.
module tb_vault_reader;
    import vault_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_all;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W:0]   entry_count;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_last;
    logic              err;
    logic              busy;

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [NUM_ENTRIES];
    assign mem_q = mem[mem_addr];

    vault_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_all     (req_all),
        .req_addr    (req_addr),
        .entry_count (entry_count),
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err         (err),
        .busy        (busy)
    );

    typedef struct {
        logic              all_mode;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W:0]   count;
        bit                exp_err;
        int                exp_bytes;
        int                exp_span;
    } vec_t;

    vec_t vecs [9];

    int  n_checks   = 0;
    int  n_fail     = 0;
    int  cyc        = 0;
    bit  rand_ready = 1'b0;
    int  rx_cnt     = 0;
    int  load_cnt   = 0;
    int  first_cyc  = 0;
    int  last_cyc   = 0;
    int  acc_cyc    = 0;
    bit  prev_stall = 1'b0;
    logic [BYTE_W-1:0] prev_data;
    logic              prev_last;

    logic [BYTE_W:0]   exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Random or full-rate sink.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop, LOAD address check, back-pressure hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            end
            if (busy && !out_valid) begin
                load_cnt++;
                if (addr_q.size() == 0) begin
                    fail_now("unexpected_load");
                end else begin
                    check("load_mem_addr", mem_addr, addr_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (rx_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_byte");
                end else begin
                    check("byte_last_data", {out_last, out_data}, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic push_expected(input vec_t v);
        int n;
        logic [ADDR_W-1:0] ent;
        logic [DATA_W-1:0] word;
        n = v.all_mode ? int'(v.count) : 1;
        for (int e = 0; e < n; e++) begin
            ent = v.all_mode ? ADDR_W'(e) : v.addr;
            addr_q.push_back(ent);
            word = mem[ent];
            for (int b = 0; b < BYTES_PER_ENTRY; b++) begin
                exp_q.push_back({(e == n - 1) && (b == BYTES_PER_ENTRY - 1),
                                 word[DATA_W-1-BYTE_W*b -: BYTE_W]});
            end
        end
    endtask

    task automatic start_req(input vec_t v);
        int guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) fail_now("req_ready_wait");
        @(posedge clk);
        #1;
        req_valid   = 1'b1;
        req_all     = v.all_mode;
        req_addr    = v.addr;
        entry_count = v.count;
        rx_cnt      = 0;
        load_cnt    = 0;
        first_cyc   = 0;
        last_cyc    = 0;
        acc_cyc     = cyc;
        if (!v.exp_err) push_expected(v);
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        entry_count = 5'd0;
        req_addr    = ADDR_W'($urandom);
        @(negedge clk);
        check("err_pulse", err, v.exp_err);
        check("busy_after_req", busy, !v.exp_err);
        check("req_ready_after_req", req_ready, v.exp_err);
        @(negedge clk);
        check("err_clears", err, 1'b0);
    endtask

    task automatic wait_done(input vec_t v);
        int guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (busy || exp_q.size() != 0) fail_now("transfer_done_wait");
        check("byte_count", rx_cnt, v.exp_bytes);
        check("load_count", load_cnt, v.exp_bytes / BYTES_PER_ENTRY);
        check("scoreboard_empty", exp_q.size(), 0);
        check("addr_queue_empty", addr_q.size(), 0);
        if (!rand_ready && !v.exp_err) begin
            check("first_byte_latency", first_cyc - acc_cyc, 2);
            check("last_byte_latency", last_cyc - acc_cyc, v.exp_span);
            check("idle_latency", cyc - acc_cyc, v.exp_span + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int guard;

        vecs[0] = '{1'b0, 4'd3,  5'd5,  1'b0, 32,  33};
        vecs[1] = '{1'b0, 4'd5,  5'd5,  1'b1, 0,   0};
        vecs[2] = '{1'b1, 4'd0,  5'd0,  1'b1, 0,   0};
        vecs[3] = '{1'b1, 4'd0,  5'd3,  1'b0, 96,  99};
        vecs[4] = '{1'b0, 4'd4,  5'd4,  1'b1, 0,   0};
        vecs[5] = '{1'b0, 4'd15, 5'd16, 1'b0, 32,  33};
        vecs[6] = '{1'b0, 4'd0,  5'd1,  1'b0, 32,  33};
        vecs[7] = '{1'b1, 4'd7,  5'd2,  1'b0, 64,  66};
        vecs[8] = '{1'b1, 4'd0,  5'd16, 1'b0, 512, 528};

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int w = 0; w < DATA_W / 32; w++) mem[i][32*w +: 32] = $urandom;
        end
        mem[0] = {32{8'hAA}};
        mem[1] = {32{8'hBB}};
        mem[2] = {32{8'hCC}};
        for (int b = 0; b < BYTES_PER_ENTRY; b++) mem[3][DATA_W-1-BYTE_W*b -: BYTE_W] = BYTE_W'(b);

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_all     = 1'b0;
        req_addr    = 4'd0;
        entry_count = 5'd0;

        @(negedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_mem_addr", mem_addr, 4'd0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_out_last", out_last, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", req_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            start_req(vecs[i]);
            wait_done(vecs[i]);
        end

        // Random back-pressure on a single entry.
        rand_ready = 1'b1;
        start_req(vecs[0]);
        wait_done(vecs[0]);
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Overwrite entry 3 while it streams; bytes must be the old snapshot.
        start_req(vecs[0]);
        repeat (5) @(negedge clk);
        mem[3] = {32{8'h5A}};
        wait_done(vecs[0]);
        start_req(vecs[0]);
        wait_done(vecs[0]);

        // Reset in the middle of a transfer.
        start_req(vecs[0]);
        guard = 0;
        while (rx_cnt < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (rx_cnt < 10) fail_now("reset_byte10_wait");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_out_last", out_last, 1'b0);
        check("midreset_out_data", out_data, 8'h00);
        check("midreset_mem_addr", mem_addr, 4'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{1'b0, 4'd0, 5'd5, 1'b0, 32, 33};
        start_req(v);
        wait_done(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
